req_ack_tx_frontend: RTL and testbench

- clk1-side front end that sits directly upstream of the 2-phase REQ/ACK sender.
- Buffers upstream valid/ready traffic in a small synchronous FIFO and presents it to the sender's valid/ready/din input.
- Synchronizes the receiver's asynchronous ack level into clk1 to drive the sender's ack input.
- Flags a sticky timeout error when the sender stalls a pending word too long.

---
 rtl/req_ack_tx_frontend_if.sv | 26 ++
 rtl/req_ack_tx_frontend.sv | 113 +++++++++++
 tb/tb_req_ack_tx_frontend.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/req_ack_tx_frontend_if.sv
// req_ack_tx_frontend_if
//   Groups the two valid/ready streams around the clk1 front end.
//   Upstream side : in_valid, in_ready, in_data
//   Sender side   : out_valid, out_ready, out_data
//   modport slave  : view taken by the front end (accepts in_*, drives out_*)
//   modport master : view taken by the surrounding logic / bench
interface req_ack_tx_frontend_if #(
    parameter int unsigned DWIDTH = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/req_ack_tx_frontend.sv
// req_ack_tx_frontend
//   clk1-side front end for the 2-phase REQ/ACK sender: a small FIFO
//   between upstream valid/ready traffic and the sender input, an ack
//   level synchronizer, and a sticky stall-timeout watchdog.
// Ports:
//   clk1, rst1_n  clock, asynchronous active-low reset
//   bus           stream interface (slave view): in_* upstream, out_* to sender
//   ack_async     receiver ack level (clk2 domain)
//   ack_sync      ack level synchronized into clk1, to sender ack
//   level         FIFO occupancy 0..DEPTH
//   timeout_err   sticky flag: TIMEOUT consecutive stall cycles seen
//   clr_err       synchronous clear of timeout_err (a coincident set wins)
module req_ack_tx_frontend #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                       clk1,
    input  logic                       rst1_n,
    req_ack_tx_frontend_if.slave       bus,
    input  logic                       ack_async,
    output logic                       ack_sync,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       timeout_err,
    input  logic                       clr_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [DWIDTH-1:0]      mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          stall_cnt;
    logic                   err_q;

    logic push;
    logic pop;
    logic stall;
    logic err_set;

    // Handshake flags come from the registered level only, so a full FIFO
    // never accepts a word in the same cycle it is being popped.
    assign bus.in_ready  = (level_q != LW'(DEPTH));
    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = mem[rd_ptr];

    assign push  = bus.in_valid & bus.in_ready;
    assign pop   = bus.out_valid & bus.out_ready;
    assign stall = bus.out_valid & ~bus.out_ready;

    assign level       = level_q;
    assign ack_sync    = sync_q[SYNC_STAGES-1];
    assign timeout_err = err_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Plain shift chain: ack_async feeds the first flop directly.
    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async};
        end
    end

    // The counter holds the number of stall cycles already completed, so the
    // TIMEOUT-th stall cycle is the one that sees TIMEOUT-1. Using >= keeps
    // the set asserted at saturation, letting it override clr_err.
    assign err_set = stall & (stall_cnt >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (!stall) begin
                stall_cnt <= '0;
            end else if (stall_cnt != CW'(TIMEOUT)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            err_q <= err_set | (err_q & ~clr_err);
        end
    end
endmodule

// File: tb/tb_req_ack_tx_frontend.sv
// tb_req_ack_tx_frontend
//   Directed bench for req_ack_tx_frontend (DEPTH=4, SYNC_STAGES=2,
//   TIMEOUT=16). Accepted words go into a scoreboard queue; a monitor
//   process pops and compares whenever the DUT completes an output transfer.
module tb_req_ack_tx_frontend;
    localparam int unsigned DWIDTH      = 8;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT     = 16;

    logic                  clk1;
    logic                  rst1_n;
    logic                  ack_async;
    logic                  ack_sync;
    logic [$clog2(DEPTH):0] level;
    logic                  timeout_err;
    logic                  clr_err;

    req_ack_tx_frontend_if #(.DWIDTH(DWIDTH)) bus ();

    req_ack_tx_frontend #(
        .DWIDTH      (DWIDTH),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk1        (clk1),
        .rst1_n      (rst1_n),
        .bus         (bus.slave),
        .ack_async   (ack_async),
        .ack_sync    (ack_sync),
        .level       (level),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [7:0]    exp_q[$];

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; a word is expected downstream if it is accepted
    // at the coming edge.
    task automatic step();
        if (rst1_n && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(bus.in_data);
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Change ack_async between edges and measure how many clk1 edges it
    // takes to reach ack_sync, then confirm it stays there.
    task automatic ack_check(input logic v);
        int unsigned seen;
        seen = 0;
        #3 ack_async = v;
        for (int e = 1; e <= 6 && seen == 0; e++) begin
            @(posedge clk1);
            #1;
            if (ack_sync == v) seen = e;
        end
        check("ack_latency_2_to_3", 32'(seen >= 2 && seen <= 3), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk1);
            #1;
            check("ack_stable", 32'(ack_sync), 32'(v));
        end
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk1);
            if (rst1_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %0h expected none at %0t", bus.out_data, $time);
                end else begin
                    check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst1_n       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        ack_async    = 1'b0;
        clr_err      = 1'b0;
        #12;
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ack_sync", 32'(ack_sync), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk1);
        rst1_n = 1'b1;
        @(posedge clk1);
        #1;

        // Fill to full, hold off a fifth word, then drain.
        for (int i = 0; i < 4; i++) begin
            push_word(8'hA1 + 8'(i));
            check("fill_level", 32'(level), 32'(i + 1));
        end
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        step();
        step();
        check("held_off_level", 32'(level), 32'd4);
        check("held_off_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("drain_level", 32'(level), 32'd0);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;

        // Push into empty FIFO: visible on the next cycle.
        check("empty_out_valid", 32'(bus.out_valid), 32'd0);
        push_word(8'h5A);
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check("lat_out_data", 32'(bus.out_data), 32'h5A);
        check("lat_level", 32'(level), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("lat_drained", 32'(level), 32'd0);
        bus.out_ready = 1'b0;

        // Streaming with level held at 2; 12 words wrap the pointers 3 times.
        push_word(8'h00);
        push_word(8'h01);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 2; i < 12; i++) begin
            bus.in_data = 8'(i);
            step();
            check("stream_level", 32'(level), 32'd2);
        end
        bus.in_valid = 1'b0;
        step();
        step();
        check("stream_drained", 32'(level), 32'd0);
        bus.out_ready = 1'b0;

        // Ack synchronizer, both directions.
        ack_check(1'b1);
        ack_check(1'b0);

        // Watchdog: 15 stall cycles are tolerated.
        push_word(8'h71);
        for (int i = 0; i < 15; i++) step();
        check("to15_err", 32'(timeout_err), 32'd0);
        bus.out_ready = 1'b1;
        step();
        check("to15_err_after_pop", 32'(timeout_err), 32'd0);
        bus.out_ready = 1'b0;

        // 16 stall cycles set the flag, and it is sticky.
        push_word(8'h72);
        for (int i = 0; i < 15; i++) step();
        check("to16_err_at_15", 32'(timeout_err), 32'd0);
        step();
        check("to16_err_at_16", 32'(timeout_err), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("to16_err_sticky", 32'(timeout_err), 32'd1);
        bus.out_ready = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_err_pulse", 32'(timeout_err), 32'd0);

        // Clear held during a saturated stall: set wins.
        push_word(8'h73);
        clr_err = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("clr_vs_set", 32'(timeout_err), 32'd1);
        clr_err = 1'b0;

        // Mid-operation reset with level 3 and the error set.
        ack_async = 1'b1;
        push_word(8'h74);
        push_word(8'h75);
        step();
        step();
        check("pre_rst_level", 32'(level), 32'd3);
        check("pre_rst_err", 32'(timeout_err), 32'd1);
        check("pre_rst_ack_sync", 32'(ack_sync), 32'd1);
        #2 rst1_n = 1'b0;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_err", 32'(timeout_err), 32'd0);
        check("arst_ack_sync", 32'(ack_sync), 32'd0);
        exp_q.delete();
        @(negedge clk1);
        rst1_n = 1'b1;
        @(posedge clk1);
        #1;
        push_word(8'hC3);
        push_word(8'hC4);
        bus.out_ready = 1'b1;
        step();
        step();
        check("post_rst_level", 32'(level), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        bus.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
